// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port RAM.
// Supports locked bursts with a fairness cap, and returns registered read data one cycle after the grant.
module ram_port_arbiter #(
  parameter int unsigned LENGTH    = 4,
  parameter int unsigned LOCATIONS = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         rw0,
  input  logic                         rw1,
  input  logic                         lock0,
  input  logic                         lock1,
  input  logic [$clog2(LOCATIONS)-1:0] addr0,
  input  logic [$clog2(LOCATIONS)-1:0] addr1,
  input  logic [LENGTH-1:0]            wdata0,
  input  logic [LENGTH-1:0]            wdata1,
  output logic                         gnt0,
  output logic                         gnt1,
  output logic                         rvalid0,
  output logic                         rvalid1,
  output logic [LENGTH-1:0]            rdata,
  output logic                         ram_rw,
  output logic [$clog2(LOCATIONS)-1:0] ram_addr,
  output logic [LENGTH-1:0]            ram_indata,
  input  logic [LENGTH-1:0]            ram_outdata
);

  localparam int unsigned AW = $clog2(LOCATIONS);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;
  logic            w_last_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_under_cap;
  logic            w_arb_last;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic [LENGTH-1:0] r_rdata;

  // State, priority pointer and burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant decision and next-state logic
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = IDLE;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    w_under_cap = (r_cnt < CW'(MAX_BURST));
    // Counter saturates at the cap so a long uncontested burst cannot wrap past it
    w_cnt_inc   = w_under_cap ? (r_cnt + CW'(1)) : r_cnt;
    w_arb_last  = r_last;

    if (r_state == OWN0 && req0 && (!req1 || w_under_cap)) begin
      w_gnt0 = 1'b1;
    end else if (r_state == OWN1 && req1 && (!req0 || w_under_cap)) begin
      w_gnt1 = 1'b1;
    end else begin
      // Losing ownership treats the owner as last-granted, so the other side wins a tie
      if (r_state == OWN0) w_arb_last = 1'b0;
      if (r_state == OWN1) w_arb_last = 1'b1;
      if (req0 && (!req1 || w_arb_last)) w_gnt0 = 1'b1;
      else if (req1)                     w_gnt1 = 1'b1;
    end

    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end

    if (w_gnt0) begin
      w_last_nxt  = 1'b0;
      w_cnt_nxt   = (r_state == OWN0) ? w_cnt_inc : CW'(1);
      w_state_nxt = lock0 ? OWN0 : IDLE;
    end else if (w_gnt1) begin
      w_last_nxt  = 1'b1;
      w_cnt_nxt   = (r_state == OWN1) ? w_cnt_inc : CW'(1);
      w_state_nxt = lock1 ? OWN1 : IDLE;
    end
  end

  // RAM port mux
  always_comb begin
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_indata = '0;
    if (w_gnt0) begin
      ram_rw     = rw0;
      ram_addr   = addr0;
      ram_indata = wdata0;
    end else if (w_gnt1) begin
      ram_rw     = rw1;
      ram_addr   = addr1;
      ram_indata = wdata1;
    end
  end

  // Read response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~rw0;
      r_rvalid1 <= w_gnt1 & ~rw1;
      if ((w_gnt0 & ~rw0) | (w_gnt1 & ~rw1)) r_rdata <= ram_outdata;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;

  logic [AW-1:0] w_unused_aw;
  assign w_unused_aw = '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: inline grant checks plus a read-response scoreboard
// fed by the stimulus and drained by a monitor on the falling edge.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, rw0, rw1, lock0, lock1;
  logic [2:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [3:0] rdata;
  logic       ram_rw;
  logic [2:0] ram_addr;
  logic [3:0] ram_indata;
  logic [3:0] ram_outdata;

  logic [3:0] mem [8];
  logic [4:0] exp_q [$];
  int         total;
  int         bad;

  ram_port_arbiter #(.LENGTH(4), .LOCATIONS(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_indata(ram_indata), .ram_outdata(ram_outdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: sync write, async read; initial contents mem[i] = 15 - i
  assign ram_outdata = mem[ram_addr];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'(15 - i);
    forever begin
      @(posedge clk);
      if (ram_rw) mem[ram_addr] <= ram_indata;
    end
  end

  // Read-response monitor
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rvalid0 || rvalid1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rvalid_unexpected: rvalid0=%0b rvalid1=%0b rdata=%h, none expected",
                   rvalid0, rvalid1, rdata);
        end else begin
          e = exp_q.pop_front();
          if ((rvalid0 && rvalid1) || (rvalid1 != e[4]) || (rdata != e[3:0])) begin
            bad++;
            $display("FAIL rresp: got rvalid0=%0b rvalid1=%0b rdata=%h, want requester %0d data %h",
                     rvalid0, rvalid1, rdata, e[4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [3:0] d);
    exp_q.push_back({id, d});
  endtask

  // Drive one cycle from a falling edge, check grants, advance to the next falling edge
  task automatic cyc(input string name,
                     input logic r0, input logic w0, input logic l0, input logic [2:0] a0, input logic [3:0] d0,
                     input logic r1, input logic w1, input logic l1, input logic [2:0] a1, input logic [3:0] d1,
                     input logic e0, input logic e1);
    req0 = r0; rw0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; rw1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    chk({name, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, e1, e0});
    @(negedge clk);
  endtask

  task automatic idle_cyc(input string name);
    cyc(name, 0,0,0,3'd0,4'h0, 0,0,0,3'd0,4'h0, 0,0);
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req0 = 1; req1 = 0; rw0 = 1; rw1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 3'd2; addr1 = '0; wdata0 = 4'h9; wdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("reset_rdata", {28'd0, rdata}, 32'd0);
    chk("reset_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("reset_ram_rw", {31'd0, ram_rw}, 32'd0);
    req0 = 0; rw0 = 0;
    rst_n = 1'b1;

    // Write then read back through requester 0
    cyc("t1_wr", 1,1,0,3'd3,4'hA, 0,0,0,3'd0,4'h0, 1,0);
    push(0, 4'hA);
    cyc("t1_rd", 1,0,0,3'd3,4'h0, 0,0,0,3'd0,4'h0, 1,0);
    idle_cyc("t1_idle");

    // Both reading, no lock: alternate 0,1,0,1 from reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(0, 4'hF); else push(1, 4'hE);
      cyc("t2_alt", 1,0,0,3'd0,4'h0, 1,0,0,3'd1,4'h0, (k % 2 == 0), (k % 2 == 1));
    end
    idle_cyc("t2_idle");

    // Locked burst by 0, requester 1 joins at cycle 2: four grants to 0, then 1, then 0
    for (int k = 0; k < 6; k++) begin
      if (k == 4) push(1, 4'hE); else push(0, 4'hD);
      cyc("t3_burst", 1,0,1,3'd2,4'h0, (k >= 2),0,0,3'd1,4'h0, (k != 4), (k == 4));
    end
    idle_cyc("t3_release");

    // Uncontested lock by 1 never switches; dropping req releases with no grant
    for (int k = 0; k < 10; k++)
      cyc("t4_lock1", 0,0,0,3'd0,4'h0, 1,1,1,3'd6,4'h3, 0,1);
    cyc("t4_drop", 0,0,0,3'd0,4'h0, 0,1,1,3'd6,4'h3, 0,0);
    push(0, 4'h3);
    cyc("t4_rdback", 1,0,0,3'd6,4'h0, 0,0,0,3'd0,4'h0, 1,0);
    idle_cyc("t4_idle");

    // Reset with a read granted but not yet captured
    req0 = 1; rw0 = 0; addr0 = 3'd0;
    #1;
    chk("t5_pre_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    #2;
    rst_n = 1'b0;
    rw0 = 1;
    #1;
    chk("t5_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("t5_rst_ram_rw", {31'd0, ram_rw}, 32'd0);
    @(negedge clk);
    chk("t5_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("t5_rdata", {28'd0, rdata}, 32'd0);
    rst_n = 1'b1;
    push(0, 4'hF);
    cyc("t5_prio0", 1,0,0,3'd0,4'h0, 1,0,0,3'd1,4'h0, 1,0);
    push(1, 4'hE);
    cyc("t5_prio1", 0,0,0,3'd0,4'h0, 1,0,0,3'd1,4'h0, 0,1);
    idle_cyc("t5_idle");

    // Read and write collide on addr 7: read wins first and sees the old value
    do_reset();
    push(0, 4'h8);
    cyc("t6_both", 1,0,0,3'd7,4'h0, 1,1,0,3'd7,4'h5, 1,0);
    cyc("t6_wr1", 0,0,0,3'd0,4'h0, 1,1,0,3'd7,4'h5, 0,1);
    push(0, 4'h5);
    cyc("t6_rdnew", 1,0,0,3'd7,4'h0, 0,0,0,3'd0,4'h0, 1,0);
    idle_cyc("t6_idle");
    idle_cyc("t6_idle2");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
